// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU-to-unified-memory path: arbiter FSM states,
// grant encoding and the SRAM macro geometry used by the CPU top.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Grant encoding: which requester owns the current access.
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Geometry of the single-port SRAM macro shared by fetch and data.
    localparam int SRAM_ADDR_W = 32;
    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_STRB_W = SRAM_DATA_W / 8;

endpackage

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-way round-robin pick between the fetch and data requesters.
// Purely combinational; the last-grant history flop lives in the parent.
module rr_arb2
    import cpu_mem_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic gnt,
    output logic conflict
);

    // On contention hand the slot to whoever did not win last time;
    // otherwise the single active requester wins.
    always_comb begin
        conflict = req_i & req_d;
        gnt      = GNT_I;
        if (conflict) begin
            gnt = ~last_grant;
        end else if (req_d) begin
            gnt = GNT_D;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous single-port SRAM between instruction fetch (I) and
// data (D). One access in flight at a time: IDLE -> ISSUE -> RESP -> IDLE,
// so a request sampled in IDLE is acked two cycles later.
module sram_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_wr,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_wstrb,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata,
    output logic [CNT_W-1:0]    conflict_cnt
);

    localparam int STRB_W = DATA_W / 8;

    state_e              state_q,        state_d;
    logic                last_grant_q,   last_grant_d;
    logic                grant_q,        grant_d;
    logic                sram_en_q,      sram_en_d;
    logic [STRB_W-1:0]   sram_we_q,      sram_we_d;
    logic [ADDR_W-1:0]   sram_addr_q,    sram_addr_d;
    logic [DATA_W-1:0]   sram_wdata_q,   sram_wdata_d;
    logic [CNT_W-1:0]    conflict_cnt_q, conflict_cnt_d;

    logic arb_gnt;
    logic arb_conflict;

    // Byte-offset bits are deliberately ignored: the SRAM is word addressed
    // and requests are never checked for alignment.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    rr_arb2 u_rr_arb2 (
        .req_i      (i_req),
        .req_d      (d_req),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt),
        .conflict   (arb_conflict)
    );

    // Next-state logic: grant and payload capture in IDLE, strobe drop in
    // ISSUE, response in RESP.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_d        = grant_q;
        sram_en_d      = sram_en_q;
        sram_we_d      = sram_we_q;
        sram_addr_d    = sram_addr_q;
        sram_wdata_d   = sram_wdata_q;
        conflict_cnt_d = conflict_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    grant_d      = arb_gnt;
                    last_grant_d = arb_gnt;
                    sram_en_d    = 1'b1;
                    if (arb_gnt == GNT_D) begin
                        sram_addr_d  = {d_addr[ADDR_W-1:2], 2'b00};
                        sram_wdata_d = d_wdata;
                        sram_we_d    = d_wr ? d_wstrb : '0;
                    end else begin
                        sram_addr_d  = {i_addr[ADDR_W-1:2], 2'b00};
                        sram_wdata_d = '0;
                        sram_we_d    = '0;
                    end
                    // Count contended grants, sticking at all-ones.
                    if (arb_conflict && (conflict_cnt_q != {CNT_W{1'b1}})) begin
                        conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The SRAM sees the enable for exactly this one cycle.
                sram_en_d = 1'b0;
                sram_we_d = '0;
                state_d   = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant history, SRAM drive registers and conflict counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            last_grant_q   <= GNT_I;
            grant_q        <= GNT_I;
            sram_en_q      <= 1'b0;
            sram_we_q      <= '0;
            sram_addr_q    <= '0;
            sram_wdata_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            grant_q        <= grant_d;
            sram_en_q      <= sram_en_d;
            sram_we_q      <= sram_we_d;
            sram_addr_q    <= sram_addr_d;
            sram_wdata_q   <= sram_wdata_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Acks are a one-cycle pulse to the owner of the access; read data is
    // passed straight from the SRAM and only meaningful alongside the ack.
    always_comb begin
        i_ack   = (state_q == RESP) && (grant_q == GNT_I);
        d_ack   = (state_q == RESP) && (grant_q == GNT_D);
        i_rdata = i_ack ? sram_rdata : '0;
        d_rdata = d_ack ? sram_rdata : '0;
    end

    assign sram_en      = sram_en_q;
    assign sram_we      = sram_we_q;
    assign sram_addr    = sram_addr_q;
    assign sram_wdata   = sram_wdata_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule
